// File: rtl/ls_counter_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : ls_counter_pkg                                                 |
// | Shared definitions for the LS-style counter family: slice width,       |
// | down-counter state encoding and a width legality check.                |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
package ls_counter_pkg;

  // Every counter in the family is built from 4-bit slices.
  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  // A counter width is legal only when it is a whole number of slices.
  function automatic bit width_ok(input int w);
    return (w > 0) && ((w % NIBBLE_W) == 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ls_down_nibble.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : ls_down_nibble                                                 |
// | One 4-bit down-count slice with parallel load and borrow-out.          |
// | Ports: CLK/CLR clock and async reset, D4 load value, LOAD sync load,   |
// |        EN_IN decrement enable (borrow-in), Q4 count,                   |
// |        BO4 = (Q4==0) & EN_IN, borrow to the next slice.                |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module ls_down_nibble
  import ls_counter_pkg::*;
(
  input  logic                CLK,
  input  logic                CLR,
  input  logic [NIBBLE_W-1:0] D4,
  input  logic                LOAD,
  input  logic                EN_IN,
  output logic [NIBBLE_W-1:0] Q4,
  output logic                BO4
);

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      Q4 <= '0;
    end else if (LOAD) begin
      Q4 <= D4;
    end else if (EN_IN) begin
      Q4 <= Q4 - 4'd1;
    end
  end

  assign BO4 = (Q4 == '0) & EN_IN;

endmodule
`default_nettype wire

// File: rtl/ls_down_counter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : ls_down_counter                                                |
// | Presettable, cascadable down counter built from 4-bit slices, with     |
// | auto-reload (divide-by-(D+1)) or one-shot behaviour at zero.           |
// | Ports: CLK clock, CLR async reset, D preload/reload value,             |
// |        LOAD_n sync load (active low), ENP/ENT count enables,           |
// |        Q count, BO = (Q==0)&ENT, TC one-cycle pulse after the zero     |
// |        step, BUSY = RUN state, DONE = EXPIRED state.                   |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module ls_down_counter
  import ls_counter_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter bit AUTO_RELOAD = 1'b1
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic [WIDTH-1:0] D,
  input  logic             LOAD_n,
  input  logic             ENP,
  input  logic             ENT,
  output logic [WIDTH-1:0] Q,
  output logic             BO,
  output logic             TC,
  output logic             BUSY,
  output logic             DONE
);

  localparam int NUM_NIB = WIDTH / NIBBLE_W;

  generate
    if (!width_ok(WIDTH)) begin : g_width_err
      $error("ls_down_counter: WIDTH must be a positive multiple of 4");
    end
  endgenerate

  state_t             state;
  logic               user_load;
  logic               count_en;
  logic               terminal;
  logic               slice_load;
  logic [WIDTH-1:0]   slice_d;
  logic [NUM_NIB:0]   chain;

  assign user_load = ~LOAD_n;
  assign count_en  = (state == RUN) & ENP & ENT;

  // The borrow chain starts at the enabled count; the borrow leaving the top
  // slice means every slice is zero while enabled, i.e. the terminal step.
  assign chain[0] = count_en;
  assign terminal = chain[NUM_NIB];

  // At the terminal step the slices are reloaded instead of wrapping: with D
  // in reload mode, with zero in one-shot mode so Q parks at 0.
  assign slice_load = user_load | terminal;
  assign slice_d    = (user_load || AUTO_RELOAD) ? D : '0;

  generate
    for (genvar i = 0; i < NUM_NIB; i++) begin : g_nibble
      ls_down_nibble u_nibble (
        .CLK   (CLK),
        .CLR   (CLR),
        .D4    (slice_d[i*NIBBLE_W +: NIBBLE_W]),
        .LOAD  (slice_load),
        .EN_IN (chain[i]),
        .Q4    (Q[i*NIBBLE_W +: NIBBLE_W]),
        .BO4   (chain[i+1])
      );
    end
  endgenerate

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state <= IDLE;
      TC    <= 1'b0;
    end else if (user_load) begin
      state <= RUN;
      TC    <= 1'b0;
    end else if (terminal) begin
      state <= AUTO_RELOAD ? RUN : EXPIRED;
      TC    <= 1'b1;
    end else begin
      TC    <= 1'b0;
    end
  end

  assign BO   = (Q == '0) & ENT;
  assign BUSY = (state == RUN);
  assign DONE = (state == EXPIRED);

endmodule
`default_nettype wire

// File: tb/tb_ls_down_counter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : tb_ls_down_counter                                             |
// | Drives a reload-mode and a one-shot instance from shared inputs and    |
// | compares both against a behavioural model every cycle.                 |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_ls_down_counter;

  logic       CLK = 1'b0;
  logic       CLR;
  logic       LOAD_n;
  logic       ENP;
  logic       ENT;
  logic [7:0] D;

  logic [7:0] q_r, q_o;
  logic       bo_r, tc_r, busy_r, done_r;
  logic       bo_o, tc_o, busy_o, done_o;

  ls_down_counter #(.WIDTH(8), .AUTO_RELOAD(1'b1)) dut_r (
    .CLK(CLK), .CLR(CLR), .D(D), .LOAD_n(LOAD_n), .ENP(ENP), .ENT(ENT),
    .Q(q_r), .BO(bo_r), .TC(tc_r), .BUSY(busy_r), .DONE(done_r)
  );

  ls_down_counter #(.WIDTH(8), .AUTO_RELOAD(1'b0)) dut_o (
    .CLK(CLK), .CLR(CLR), .D(D), .LOAD_n(LOAD_n), .ENP(ENP), .ENT(ENT),
    .Q(q_o), .BO(bo_o), .TC(tc_o), .BUSY(busy_o), .DONE(done_o)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: index 0 = one-shot, 1 = auto-reload. Phase 0 idle, 1 running, 2 expired.
  logic [7:0] mq  [2];
  int         mph [2];
  logic       mtc [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      mq[m] = 8'd0; mph[m] = 0; mtc[m] = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int m = 0; m < 2; m++) begin
      if (CLR) begin
        mq[m] = 8'd0; mph[m] = 0; mtc[m] = 1'b0;
      end else if (!LOAD_n) begin
        mq[m] = D; mph[m] = 1; mtc[m] = 1'b0;
      end else if (mph[m] == 1 && ENP && ENT) begin
        if (mq[m] != 0) begin
          mq[m] = mq[m] - 8'd1; mtc[m] = 1'b0;
        end else begin
          mtc[m] = 1'b1;
          if (m == 1) mq[m] = D;
          else        mph[m] = 2;
        end
      end else begin
        mtc[m] = 1'b0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/q_r"},    q_r,    mq[1]);
    chk({tag, "/tc_r"},   tc_r,   mtc[1]);
    chk({tag, "/busy_r"}, busy_r, (mph[1] == 1));
    chk({tag, "/done_r"}, done_r, (mph[1] == 2));
    chk({tag, "/bo_r"},   bo_r,   (mq[1] == 0) && ENT);
    chk({tag, "/q_o"},    q_o,    mq[0]);
    chk({tag, "/tc_o"},   tc_o,   mtc[0]);
    chk({tag, "/busy_o"}, busy_o, (mph[0] == 1));
    chk({tag, "/done_o"}, done_o, (mph[0] == 2));
    chk({tag, "/bo_o"},   bo_o,   (mq[0] == 0) && ENT);
  endtask

  task automatic tick(input string tag);
    @(posedge CLK);
    model_step();
    #1;
    check_all(tag);
  endtask

  logic [7:0] exp_q  [8];
  logic       exp_tc [8];

  initial begin
    CLR = 1'b1; LOAD_n = 1'b1; ENP = 1'b0; ENT = 1'b0; D = 8'h00;
    model_reset();
    #2;
    check_all("reset");
    chk("reset_bo_ent0", bo_r, 1'b0);
    ENT = 1'b1;
    #1;
    chk("reset_bo_ent1", bo_r, 1'b1);
    tick("reset_hold");
    CLR = 1'b0;

    // Borrow across the nibble boundary.
    D = 8'h10; LOAD_n = 1'b0; ENP = 1'b1; ENT = 1'b1;
    tick("t1_load");
    chk("t1_q_load", q_r, 8'h10);
    LOAD_n = 1'b1;
    tick("t1_c1");
    chk("t1_q_0f", q_r, 8'h0F);
    tick("t1_c2");
    chk("t1_q_0e", q_r, 8'h0E);
    chk("t1_busy", busy_r, 1'b1);

    // Reload period of 4 with D=3.
    D = 8'h03; LOAD_n = 1'b0;
    tick("t2_load");
    LOAD_n = 1'b1;
    exp_q  = '{8'd2, 8'd1, 8'd0, 8'd3, 8'd2, 8'd1, 8'd0, 8'd3};
    exp_tc = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 8; i++) begin
      tick("t2_run");
      chk("t2_q_seq",  q_r,  exp_q[i]);
      chk("t2_tc_seq", tc_r, exp_tc[i]);
    end

    // One-shot from D=2.
    D = 8'h02; LOAD_n = 1'b0;
    tick("t3_load");
    LOAD_n = 1'b1;
    tick("t3_c1");
    chk("t3_q1", q_o, 8'd1);
    tick("t3_c2");
    chk("t3_q0", q_o, 8'd0);
    chk("t3_tc_pre", tc_o, 1'b0);
    tick("t3_c3");
    chk("t3_tc", tc_o, 1'b1);
    chk("t3_done", done_o, 1'b1);
    chk("t3_busy", busy_o, 1'b0);
    tick("t3_c4");
    chk("t3_tc_end", tc_o, 1'b0);
    chk("t3_q_hold", q_o, 8'd0);
    chk("t3_bo", bo_o, 1'b1);
    ENT = 1'b0;
    #1;
    chk("t3_bo_ent0", bo_o, 1'b0);
    ENT = 1'b1;

    // Enable gating at Q=5.
    D = 8'h05; LOAD_n = 1'b0;
    tick("t4_load");
    LOAD_n = 1'b1; ENT = 1'b0;
    tick("t4_ent0");
    chk("t4_q_ent0", q_r, 8'h05);
    chk("t4_bo_ent0", bo_r, 1'b0);
    ENT = 1'b1; ENP = 1'b0;
    tick("t4_enp0");
    chk("t4_q_enp0", q_r, 8'h05);
    chk("t4_bo_enp0", bo_r, 1'b0);
    ENP = 1'b1;

    // Asynchronous clear mid-count.
    D = 8'h05; LOAD_n = 1'b0;
    tick("t5_load");
    LOAD_n = 1'b1;
    tick("t5_c1");
    tick("t5_c2");
    chk("t5_q3", q_r, 8'h03);
    #2;
    CLR = 1'b1;
    model_reset();
    #1;
    check_all("t5_clr");
    chk("t5_q0", q_r, 8'h00);
    chk("t5_busy", busy_r, 1'b0);
    chk("t5_tc", tc_r, 1'b0);
    tick("t5_hold");
    chk("t5_q_hold", q_r, 8'h00);
    CLR = 1'b0;

    // Load beats a same-edge terminal step.
    D = 8'h01; LOAD_n = 1'b0;
    tick("t6_load1");
    LOAD_n = 1'b1;
    tick("t6_to0");
    chk("t6_q0", q_r, 8'h00);
    D = 8'h7A; LOAD_n = 1'b0;
    tick("t6_load");
    chk("t6_q7a", q_r, 8'h7A);
    chk("t6_tc", tc_r, 1'b0);
    chk("t6_busy", busy_r, 1'b1);
    chk("t6_q7a_o", q_o, 8'h7A);
    LOAD_n = 1'b1;

    // Randomised traffic, biased toward short reload values so zero is hit often.
    for (int i = 0; i < 800; i++) begin
      LOAD_n = ($urandom_range(0, 15) != 0);
      D      = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'($urandom_range(0, 4));
      ENP    = ($urandom_range(0, 7) != 0);
      ENT    = ($urandom_range(0, 7) != 0);
      tick("rand");
      if ($urandom_range(0, 99) == 0) begin
        #2;
        CLR = 1'b1;
        model_reset();
        #1;
        check_all("rand_clr");
        CLR = 1'b0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
